// File: rtl/reg_op_pkg.sv
// Shared definitions for the register-operation sequencer: the register's
// mux-select encoding and the sequencer FSM state type.
package reg_op_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_COMP = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/reg_op_slot.sv
// One command holding register (valid, op, count, data) with load and clear.
// Clear wins over load; only the valid bit is reset.
module reg_op_slot
  import reg_op_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clr,
  input  logic [1:0]        op_in,
  input  logic [CNT_W-1:0]  count_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [1:0]        op,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [1:0]        op_q, op_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    count_d = count_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      op_d    = op_in;
      count_d = count_in;
      data_d  = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
    op_q    <= op_d;
    count_q <= count_d;
    data_q  <= data_d;
  end

  assign valid = valid_q;
  assign op    = op_q;
  assign count = count_q;
  assign data  = data_q;

endmodule

// File: rtl/reg_op_sequencer.sv
// Command stage for the 4-bit hold/complement/shift register: replays each
// accepted command on s/shift_in_R/shift_in_L for its programmed cycle count.
module reg_op_sequencer
  import reg_op_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [1:0]        s,
  output logic              shift_in_R,
  output logic              shift_in_L,
  output logic              busy,
  output logic              done
);

  function automatic logic shift_bit(input logic [DATA_W-1:0] data,
                                     input logic [CNT_W-1:0]  k);
    logic [DATA_W-1:0] sh;
    sh = data >> k;
    return sh[0];
  endfunction

  logic              act_valid, pend_valid;
  logic [1:0]        act_op, pend_op;
  logic [CNT_W-1:0]  act_count, pend_count;
  logic [DATA_W-1:0] act_data, pend_data;

  logic              act_load, act_clr, pend_load, pend_clr;
  logic [1:0]        src_op;
  logic [CNT_W-1:0]  src_count;
  logic [DATA_W-1:0] src_data;

  logic              accept, last, free;
  logic              nxt_valid;
  logic [1:0]        nxt_op;
  logic [CNT_W-1:0]  nxt_count;
  logic [DATA_W-1:0] nxt_data;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [1:0]        s_q, s_d;
  logic              shift_q, shift_d;
  logic              done_q, done_d;

  reg_op_slot #(.CNT_W(CNT_W), .DATA_W(DATA_W)) u_act (
    .clk      (clk),
    .reset    (reset),
    .load     (act_load),
    .clr      (act_clr),
    .op_in    (src_op),
    .count_in (src_count),
    .data_in  (src_data),
    .valid    (act_valid),
    .op       (act_op),
    .count    (act_count),
    .data     (act_data)
  );

  reg_op_slot #(.CNT_W(CNT_W), .DATA_W(DATA_W)) u_pend (
    .clk      (clk),
    .reset    (reset),
    .load     (pend_load),
    .clr      (pend_clr),
    .op_in    (cmd_op),
    .count_in (cmd_count),
    .data_in  (cmd_data),
    .valid    (pend_valid),
    .op       (pend_op),
    .count    (pend_count),
    .data     (pend_data)
  );

  always_comb begin
    cmd_ready = !pend_valid && !flush;
    accept    = cmd_valid && cmd_ready;
    last      = (state_q == RUN) &&
                ((act_count == '0) || (k_q == act_count - CNT_W'(1)));
    free      = (state_q == IDLE) || last;

    act_load  = 1'b0;
    act_clr   = 1'b0;
    pend_load = 1'b0;
    pend_clr  = 1'b0;
    src_op    = pend_op;
    src_count = pend_count;
    src_data  = pend_data;
    k_d       = k_q + CNT_W'(1);

    if (flush) begin
      act_clr  = 1'b1;
      pend_clr = 1'b1;
      k_d      = '0;
    end else if (free) begin
      // Engine free next cycle: the pending slot has priority over a new offer.
      k_d = '0;
      if (pend_valid) begin
        act_load = 1'b1;
        pend_clr = 1'b1;
      end else if (accept) begin
        act_load  = 1'b1;
        src_op    = cmd_op;
        src_count = cmd_count;
        src_data  = cmd_data;
      end else begin
        act_clr = 1'b1;
      end
    end else begin
      pend_load = accept;
    end

    nxt_valid = act_load || (act_valid && !act_clr);
    nxt_op    = act_load ? src_op    : act_op;
    nxt_count = act_load ? src_count : act_count;
    nxt_data  = act_load ? src_data  : act_data;
    state_d   = nxt_valid ? RUN : IDLE;

    // Outputs are registered, so they are derived from next-cycle slot and k.
    s_d     = OP_HOLD;
    shift_d = 1'b0;
    done_d  = 1'b0;
    if (nxt_valid) begin
      if (nxt_count == '0) begin
        done_d = 1'b1;
      end else begin
        s_d     = nxt_op;
        shift_d = shift_bit(nxt_data, k_d);
        done_d  = (k_d == nxt_count - CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= OP_HOLD;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  assign s          = s_q;
  assign shift_in_R = shift_q;
  assign shift_in_L = shift_q;
  assign done       = done_q;
  assign busy       = act_valid || pend_valid;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed and randomised checks of reg_op_sequencer: reset, single command,
// back-to-back, zero/long counts, flush, and a queue-based reference model.
module tb_reg_op_sequencer;
  import reg_op_pkg::*;

  localparam int CNT_W  = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset, flush, cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [CNT_W-1:0]  cmd_count;
  logic [DATA_W-1:0] cmd_data;
  logic [1:0]        s;
  logic              shift_in_R, shift_in_L, busy, done;

  int applied     = 0;
  int miscompares = 0;

  logic [5:0] obs;
  assign obs = {s, shift_in_R, shift_in_L, done, busy};

  always #5 clk = ~clk;

  reg_op_sequencer #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_count  (cmd_count),
    .cmd_data   (cmd_data),
    .s          (s),
    .shift_in_R (shift_in_R),
    .shift_in_L (shift_in_L),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                       input logic [DATA_W-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
  endtask

  task automatic test_reset();
    offer(OP_SHR, 4'd5, 8'hFF);
    tick();
    cmd_valid = 1'b0;
    tick();
    applied++;
    if (obs !== 6'b10_1_1_0_1) begin
      miscompares++;
      $display("FAIL reset_precmd obs=%b expected=%b", obs, 6'b10_1_1_0_1);
    end
    reset = 1'b1;
    tick();
    applied++;
    if (obs !== 6'b00_0_0_0_0) begin
      miscompares++;
      $display("FAIL reset_first obs=%b expected=%b", obs, 6'b0);
    end
    tick();
    reset = 1'b0;
    #1;
    applied++;
    if (obs !== 6'b00_0_0_0_0) begin
      miscompares++;
      $display("FAIL reset_after obs=%b expected=%b", obs, 6'b0);
    end
    applied++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got=%b expected=1", cmd_ready);
    end
    tick();
    applied++;
    if (obs !== 6'b00_0_0_0_0) begin
      miscompares++;
      $display("FAIL reset_stays_idle obs=%b expected=%b", obs, 6'b0);
    end
  endtask

  task automatic test_single_shr();
    logic [5:0] exp_tbl [4];
    exp_tbl = '{6'b10_1_1_0_1, 6'b10_0_0_0_1, 6'b10_1_1_1_1, 6'b00_0_0_0_0};
    offer(OP_SHR, 4'd3, 8'b0000_0101);
    #1;
    applied++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready got=%b expected=1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applied++;
      if (obs !== exp_tbl[i]) begin
        miscompares++;
        $display("FAIL single_cycle%0d obs=%b expected=%b", i, obs, exp_tbl[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_tbl [5];
    exp_tbl = '{6'b01_1_1_0_1, 6'b01_1_1_1_1, 6'b11_0_0_0_1, 6'b11_1_1_1_1,
                6'b00_0_0_0_0};
    offer(OP_COMP, 4'd2, 8'b0000_0011);
    tick();
    offer(OP_SHL, 4'd2, 8'b0000_0010);
    applied++;
    if (obs !== exp_tbl[0]) begin
      miscompares++;
      $display("FAIL b2b_cycle0 obs=%b expected=%b", obs, exp_tbl[0]);
    end
    tick();
    cmd_valid = 1'b0;
    applied++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ready_pend_full got=%b expected=0", cmd_ready);
    end
    for (int i = 1; i < 5; i++) begin
      applied++;
      if (obs !== exp_tbl[i]) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d obs=%b expected=%b", i, obs, exp_tbl[i]);
      end
      tick();
    end
    applied++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready_after got=%b expected=1", cmd_ready);
    end
  endtask

  task automatic test_count_edges();
    logic [5:0] e;
    logic       b;
    offer(OP_SHL, 4'd0, 8'hFF);
    tick();
    cmd_valid = 1'b0;
    applied++;
    if (obs !== 6'b00_0_0_1_1) begin
      miscompares++;
      $display("FAIL zero_count obs=%b expected=%b", obs, 6'b00_0_0_1_1);
    end
    tick();
    applied++;
    if (obs !== 6'b00_0_0_0_0) begin
      miscompares++;
      $display("FAIL zero_count_after obs=%b expected=%b", obs, 6'b0);
    end
    offer(OP_SHR, 4'd15, 8'hFF);
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      b = (k < 8);
      e = {2'b10, b, b, (k == 14), 1'b1};
      applied++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL long_k%0d obs=%b expected=%b", k, obs, e);
      end
      tick();
    end
    applied++;
    if (obs !== 6'b00_0_0_0_0) begin
      miscompares++;
      $display("FAIL long_after obs=%b expected=%b", obs, 6'b0);
    end
  endtask

  task automatic test_flush();
    offer(OP_SHR, 4'd5, 8'b0000_0100);
    tick();
    offer(OP_SHL, 4'd3, 8'h00);
    tick();
    applied++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_pend_full_ready got=%b expected=0", cmd_ready);
    end
    offer(OP_COMP, 4'd1, 8'hFF);
    tick();
    applied++;
    if (obs !== 6'b10_1_1_0_1) begin
      miscompares++;
      $display("FAIL flush_k2 obs=%b expected=%b", obs, 6'b10_1_1_0_1);
    end
    flush = 1'b1;
    #1;
    applied++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready got=%b expected=0", cmd_ready);
    end
    tick();
    flush     = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applied++;
      if (obs !== 6'b00_0_0_0_0) begin
        miscompares++;
        $display("FAIL flush_idle%0d obs=%b expected=%b", i, obs, 6'b0);
      end
      tick();
    end
  endtask

  typedef struct {
    logic [1:0]        op;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data;
  } mcmd_t;

  task automatic test_random();
    mcmd_t q[$];
    mcmd_t f;
    int    fk = 0;
    int    lenf;
    int    accepts = 0, cancelled = 0, done_seen = 0;
    logic  mready, macc, b;
    logic [5:0] e;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (q.size() == 0) begin
        e = 6'b00_0_0_0_0;
      end else begin
        f = q[0];
        if (f.cnt == 0) begin
          e = 6'b00_0_0_1_1;
        end else begin
          b = (fk < DATA_W) ? f.data[3'(fk)] : 1'b0;
          e = {f.op, b, b, (fk == int'(f.cnt) - 1), 1'b1};
        end
      end
      applied++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL rand_cyc%0d obs=%b expected=%b", cyc, obs, e);
      end
      if (done === 1'b1) done_seen++;

      flush = (cyc < 520) && ($urandom_range(0, 19) == 0);
      if (!cmd_valid && cyc < 520 && $urandom_range(0, 1) == 1) begin
        offer(2'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 4)),
              8'($urandom));
      end
      mready = (q.size() < 2) && !flush;
      #1;
      applied++;
      if (cmd_ready !== mready) begin
        miscompares++;
        $display("FAIL rand_ready_cyc%0d got=%b expected=%b", cyc, cmd_ready, mready);
      end
      macc = cmd_valid && mready;
      f    = '{op: cmd_op, cnt: cmd_count, data: cmd_data};
      tick();

      if (flush) begin
        if (q.size() > 0) begin
          lenf = (q[0].cnt == 0) ? 1 : int'(q[0].cnt);
          cancelled += q.size() - ((fk == lenf - 1) ? 1 : 0);
        end
        q.delete();
        fk = 0;
      end else begin
        if (q.size() > 0) begin
          lenf = (q[0].cnt == 0) ? 1 : int'(q[0].cnt);
          fk++;
          if (fk == lenf) begin
            void'(q.pop_front());
            fk = 0;
          end
        end
        if (macc) q.push_back(f);
      end
      if (macc) begin
        cmd_valid = 1'b0;
        accepts++;
      end
    end
    flush = 1'b0;
    applied++;
    if (done_seen != accepts - cancelled) begin
      miscompares++;
      $display("FAIL rand_done_count got=%0d expected=%0d", done_seen, accepts - cancelled);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = '0;
    cmd_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_single_shr();
    test_back_to_back();
    test_count_edges();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
